// File: rtl/seq_word_serializer.sv
// Parallel-to-serial word feeder: shifts each accepted word out MSB-first on w,
// zero-gap back-to-back. Define SERIALIZER_PARITY_EN to append an even-parity bit.
module seq_word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

`ifdef SERIALIZER_PARITY_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH);
`else
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             wv_q, wv_d;
  logic             last;
  logic             accept;
  logic             fill;

  assign last       = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == IDLE) || last;
  assign accept     = load_valid && load_ready;

  // The parity bit rides in the vacated LSB, so it falls out right after the data LSB.
`ifdef SERIALIZER_PARITY_EN
  assign fill = ^data_in;
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      w_q     <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      wv_q    <= wv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    w_d     = 1'b0;
    wv_d    = 1'b0;
    if (accept) begin
      w_d     = data_in[WIDTH-1];
      wv_d    = 1'b1;
      sreg_d  = {data_in[WIDTH-2:0], fill};
      cnt_d   = LOAD_CNT;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        w_d    = sreg_q[WIDTH-1];
        wv_d   = 1'b1;
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign w       = w_q;
  assign w_valid = wv_q;
  assign busy    = (state_q == SHIFT);
  assign done    = last;

endmodule

// File: tb/tb_seq_word_serializer.sv
// Self-checking bench for seq_word_serializer against a queue-of-pending-bits model.
module tb_seq_word_serializer;
  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, w, w_valid, busy, done;

  int errors = 0;
  int checks = 0;

  // Model: bits still to appear on w; front is the bit currently on w.
  logic q[$];

  seq_word_serializer #(.WIDTH(W)) dut (
    .clk(clk), .Reset(Reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .w(w), .w_valid(w_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [F-1:0] frame(input logic [W-1:0] d);
`ifdef SERIALIZER_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  function automatic logic [4:0] exp_vec();
    logic b;
    b = (q.size() > 0) ? q[0] : 1'b0;
    return {b, q.size() > 0, q.size() > 0, q.size() == 1, q.size() <= 1};
  endfunction

  function automatic logic [4:0] dut_vec();
    return {w, w_valid, busy, done, load_ready};
  endfunction

  // Advance one clock edge and apply the model's rule for that edge.
  task automatic tick();
    logic         acc;
    logic [F-1:0] fr;
    acc = load_valid && (q.size() <= 1);
    fr  = frame(data_in);
    @(posedge clk);
    if (!Reset) q.delete();
    else if (acc) begin
      q.delete();
      for (int i = F - 1; i >= 0; i--) q.push_back(fr[i]);
    end else if (q.size() > 0) void'(q.pop_front());
    #1;
  endtask

  task automatic test_reset();
    load_valid = 1'b1;
    data_in    = 8'hA5;
    #1;
    checks++;
    if (dut_vec() !== 5'b00001) begin
      errors++; $display("FAIL reset_state: got %b want 00001", dut_vec());
    end
    tick();
    checks++;
    if (dut_vec() !== 5'b00001) begin
      errors++; $display("FAIL reset_beats_accept: got %b want 00001", dut_vec());
    end
    load_valid = 1'b0;
    Reset = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL post_reset_idle: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic run_word(input string name, input logic [W-1:0] d, input logic [F-1:0] want);
    logic [F-1:0] got;
    got = '0;
    data_in    = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = ~d;
    for (int c = 1; c <= F; c++) begin
      checks++;
      if (dut_vec() !== exp_vec() || done !== (c == F)) begin
        errors++; $display("FAIL %s_cycle%0d: got %b want %b", name, c, dut_vec(), exp_vec());
      end
      got = {got[F-2:0], w};
      if (c < F) tick();
    end
    tick();
    checks++;
    if (dut_vec() !== 5'b00001) begin
      errors++; $display("FAIL %s_after: got %b want 00001", name, dut_vec());
    end
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s_stream: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_single_word();
`ifdef SERIALIZER_PARITY_EN
    run_word("single", 8'b10100101, 9'b101001010);
`else
    run_word("single", 8'b10100101, 8'b10100101);
`endif
  endtask

  task automatic test_parity();
`ifdef SERIALIZER_PARITY_EN
    run_word("parity", 8'b10100100, 9'b101001001);
`else
    run_word("parity", 8'b10100100, 8'b10100100);
`endif
  endtask

  task automatic test_back_to_back();
    logic [2*F-1:0] got;
    int             nvalid;
    got = '0;
    nvalid = 0;
    data_in    = 8'hA5;
    load_valid = 1'b1;
    tick();
    data_in = 8'h3C;
    for (int c = 1; c <= 2 * F + 2; c++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_cycle%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (w_valid) begin
        got = {got[2*F-2:0], w};
        nvalid++;
      end
      if (c == F) begin
        checks++;
        if (load_ready !== 1'b1 || done !== 1'b1) begin
          errors++; $display("FAIL b2b_second_accept: ready=%b done=%b want 1 1", load_ready, done);
        end
      end
      tick();
      if (c == F) load_valid = 1'b0;
    end
    checks++;
    if (got !== {frame(8'hA5), frame(8'h3C)} || nvalid != 2 * F) begin
      errors++; $display("FAIL b2b_stream: got %b (%0d bits) want %b (%0d bits)",
                         got, nvalid, {frame(8'hA5), frame(8'h3C)}, 2 * F);
    end
  endtask

  task automatic test_load_while_busy();
    int ones;
    ones = 0;
    data_in    = 8'hFF;
    load_valid = 1'b1;
    tick();
    data_in = 8'h00;
    for (int c = 1; c <= F; c++) begin
      checks++;
      if (dut_vec() !== exp_vec() || load_ready !== (c == F)) begin
        errors++; $display("FAIL busy_cycle%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (c <= W && w === 1'b1) ones++;
      tick();
    end
    load_valid = 1'b0;
    checks++;
    if (ones != W || w_valid !== 1'b1 || w !== 1'b0) begin
      errors++; $display("FAIL busy_ones: got %0d ones, next w=%b vld=%b want %0d 0 1", ones, w, w_valid, W);
    end
    while (q.size() > 0) tick();
  endtask

  task automatic test_reset_mid_word();
    data_in    = 8'hF0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    #2;
    Reset = 1'b0;
    q.delete();
    #1;
    checks++;
    if (dut_vec() !== 5'b00001) begin
      errors++; $display("FAIL reset_mid_word: got %b want 00001", dut_vec());
    end
    @(negedge clk);
    tick();
    Reset = 1'b1;
    for (int c = 0; c < F + 2; c++) begin
      tick();
      checks++;
      if (dut_vec() !== 5'b00001) begin
        errors++; $display("FAIL reset_no_resume%0d: got %b want 00001", c, dut_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      data_in    = W'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        Reset = 1'b0;
        q.delete();
      end
      tick();
      Reset = 1'b1;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    load_valid = 1'b0;
    while (q.size() > 0) tick();
  endtask

  task automatic test_detector();
    logic [1:0] hist;
    int         zc;
    hist = 2'b00;
    zc   = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if ({hist, w} == 3'b101) zc++;
      hist = {hist[0], w};
    end
    data_in    = 8'b00010100;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < F + 6; c++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL detector_cycle%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if ({hist, w} == 3'b101) zc++;
      hist = {hist[0], w};
      tick();
    end
    checks++;
    if (zc != 1) begin
      errors++; $display("FAIL detector_z_count: got %0d want 1", zc);
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single_word();
        test_parity();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_word();
        test_random();
        test_detector();
      end
      begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_word_serializer.md
Name: seq_word_serializer

Overview:
- Upstream feeder for the 101 Mealy sequence detector.
- Accepts a parallel WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on serial line w.
- w is driven to 0 whenever no word is in flight, so idle gaps never create spurious patterns downstream.
- Supports back-to-back words with no gap cycle.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
Reset  input  1  asynchronous active-low reset; clears all state immediately when low
data_in  input  WIDTH  parallel word; sampled only on an accepted load
load_valid  input  1  upstream has a word on data_in
load_ready  output  1  block can accept a word this cycle (combinational from state/counter)
w  output  1  serial bit stream; registered
w_valid  output  1  w carries a data bit this cycle; registered
busy  output  1  high while in SHIFT state
done  output  1  high during the cycle the last bit of a word is on w

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; shift register=0; bit counter=0.
  - w=0, w_valid=0, busy=0, done=0, load_ready=1.
  - A word in flight is discarded; no partial-word completion after Reset deasserts.
- State machine has two states, IDLE and SHIFT. Internal registers:
  - Shift register sreg, WIDTH bits.
  - Counter cnt, $clog2(WIDTH) bits (minimum 1), counting remaining bits after the current one.
- load_ready = (state==IDLE) | (state==SHIFT & cnt==0).
- Accept = load_valid & load_ready at a rising edge.
- On Accept:
  - w <= data_in[WIDTH-1]; w_valid <= 1.
  - sreg <= {data_in[WIDTH-2:0], 1'b0}; cnt <= WIDTH-1; state <= SHIFT.
- SHIFT with cnt != 0, each edge:
  - w <= sreg[WIDTH-1]; sreg <= sreg << 1; cnt <= cnt-1.
  - load_valid is ignored (load_ready=0); data_in is not sampled.
- SHIFT with cnt == 0 (last bit on w, done=1):
  - If Accept: the next word's MSB appears on the following cycle. w_valid stays 1 and state stays SHIFT (zero-gap back-to-back).
  - Otherwise: w <= 0, w_valid <= 0, state <= IDLE.
- In IDLE without Accept: w stays 0 and w_valid stays 0.
- Latency: MSB is on w in the cycle immediately after the accepting edge. A word occupies exactly WIDTH consecutive w_valid cycles.
- busy = (state==SHIFT). done = (state==SHIFT & cnt==0). Both are decoded from registers, so they are glitch-free relative to w.
- If data_in changes after acceptance, the word in flight is unaffected.
- Reset asserted in the same cycle as Accept: reset wins and the word is not accepted.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the LSB, one extra bit is emitted: even parity = XOR of all WIDTH data bits, computed at Accept and stored.
  - Frame length is WIDTH+1 w_valid cycles; cnt is loaded with WIDTH.
  - done and load_ready assert during the parity-bit cycle instead of the LSB cycle.
- Not defined: frame is WIDTH bits exactly; no parity logic is present.

Test Plan:
- Single word: WIDTH=8, Reset released, data_in=8'b10100101, load_valid pulsed 1 cycle.
  - Expect w=1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance.
  - w_valid=1 on cycles 1..8; done=1 only on cycle 8.
  - Expect w=0, w_valid=0, load_ready=1 on cycle 9.
- Back-to-back: 8'hA5 then 8'h3C, load_valid held high.
  - Second word accepted on the cycle where done=1.
  - w shows 16 contiguous valid bits 10100101 00111100 with no gap.
  - Only two Accepts occur.
- Load while busy: after 8'hFF is accepted, present data_in=8'h00 with load_valid=1 during cycles 2..7.
  - load_ready=0 throughout; output remains eight 1s.
  - 8'h00 is accepted only at the cycle-8 edge.
- Reset mid-word: accept 8'hF0, drive Reset=0 asynchronously during cycle 3.
  - w, w_valid and busy go 0 immediately; load_ready=1.
  - After release, no remaining bits of 8'hF0 appear.
- Parity (SERIALIZER_PARITY_EN defined):
  - 8'b10100101 -> 9 bits 1,0,1,0,0,1,0,1,0; done on bit 9.
  - 8'b10100100 -> ninth bit = 1.
- Downstream integration: serialize 8'b00010100 into the 101 Mealy detector.
  - Detector output z=1 exactly once, in the cycle after the serial bit pattern 1,0,1 completes.
  - Idle zeros before and after the word produce no z pulse.
